ahb_bus_arbiter: RTL



---
 rtl/ahb_bus_arbiter_pkg.sv | 47 ++++
 rtl/ahb_rr_picker.sv | 29 ++
 rtl/ahb_bus_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/ahb_bus_arbiter_pkg.sv
// Shared AHB arbiter definitions: transfer/burst encodings, arbiter states and
// the burst-length helper used by the beat counter.
`ifndef AHB_MW
`define AHB_MW(n) (((n) > 1) ? $clog2(n) : 1)
`endif

package ahb_bus_arbiter_pkg;

    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_t;

    typedef enum logic [1:0] {
        ST_PARK,
        ST_BURST,
        ST_OPEN,
        ST_LOCKED
    } arb_state_t;

    // Zero means unbounded (INCR).
    function automatic logic [CNT_W-1:0] beats_per_burst(input hburst_t burst);
        case (burst)
            HBURST_SINGLE:                return 5'd1;
            HBURST_WRAP4,  HBURST_INCR4:  return 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  return 5'd8;
            HBURST_WRAP16, HBURST_INCR16: return 5'd16;
            default:                      return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin select: first requester strictly after ptr,
// wrapping, with ptr itself considered last.
module ahb_rr_picker #(
    parameter int N  = 4,
    parameter int MW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [MW-1:0] ptr,
    output logic [MW-1:0] idx,
    output logic          valid
);

    logic [MW-1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        // Scan farthest offset first so the nearest requester is written last.
        for (int off = N; off >= 1; off--) begin
            cand = MW'((int'(ptr) + off) % N);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter: tracks burst/lock progress from the muxed bus and
// hands the grant over only at re-arbitration points, parking when idle.
module ahb_bus_arbiter
    import ahb_bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int MW             = `AHB_MW(NUM_MASTERS)
) (
    input  logic                   hclk,
    input  logic                   hreset,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic [1:0]             htrans,
    input  logic [2:0]             hburst,
    input  logic                   hready,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [MW-1:0]          hmaster,
    output logic                   hmastlock
);

    localparam logic [MW-1:0]          DEF_IDX   = MW'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

    arb_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [MW-1:0]          grant_idx_q, grant_idx_d;
    logic [MW-1:0]          ptr_q, ptr_d;
    logic [MW-1:0]          hmaster_q, hmaster_d;
    logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;
    logic                   hmastlock_q, hmastlock_d;

    htrans_t          trans;
    logic [CNT_W-1:0] burst_len;
    logic             nonseq_acc, seq_acc, owner_req, owner_lock;
    logic             last_fixed, open_beat, rap;
    logic [MW-1:0]    pick_idx;
    logic             pick_valid;

    assign trans     = htrans_t'(htrans);
    assign burst_len = beats_per_burst(hburst_t'(hburst));

    ahb_rr_picker #(
        .N  (NUM_MASTERS),
        .MW (MW)
    ) u_picker (
        .req   (hbusreq),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // NOTE: every signal assigned in this block gets a default first; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        nonseq_acc = hready && (trans == HTRANS_NONSEQ);
        seq_acc    = hready && (trans == HTRANS_SEQ);
        owner_req  = hbusreq[grant_idx_q];
        owner_lock = hlock[grant_idx_q];

        // The counter holds the beats still owed after the accepted NONSEQ, so a
        // fixed burst's final SEQ is the one that takes it from 1 to 0.
        last_fixed = seq_acc && (cnt_q == 5'd1);
        open_beat  = (nonseq_acc && (burst_len <= 5'd1)) || (seq_acc && (cnt_q == '0));
        rap        = hready && !owner_lock &&
                     ((trans == HTRANS_IDLE) || last_fixed || (open_beat && !owner_req));

        cnt_d = cnt_q;
        if (nonseq_acc) begin
            cnt_d = (burst_len == '0) ? '0 : burst_len - 5'd1;
        end else if (seq_acc && (cnt_q != '0)) begin
            cnt_d = cnt_q - 5'd1;
        end

        state_d = state_q;
        if (rap) begin
            state_d = pick_valid ? ST_OPEN : ST_PARK;
        end else if (hready) begin
            if (owner_lock) begin
                state_d = ST_LOCKED;
            end else if (nonseq_acc && (state_q != ST_LOCKED)) begin
                state_d = (burst_len > 5'd1) ? ST_BURST : ST_OPEN;
            end
        end

        grant_idx_d = grant_idx_q;
        ptr_d       = ptr_q;
        if (rap) begin
            grant_idx_d = pick_valid ? pick_idx : DEF_IDX;
            ptr_d       = pick_valid ? pick_idx : ptr_q;
        end
        hgrant_d = NUM_MASTERS'(1) << grant_idx_d;

        hmaster_d   = hready ? grant_idx_q : hmaster_q;
        hmastlock_d = hready ? owner_lock  : hmastlock_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values computed above, regardless of statement order.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q     <= ST_PARK;
            cnt_q       <= '0;
            grant_idx_q <= DEF_IDX;
            ptr_q       <= DEF_IDX;
            hgrant_q    <= DEF_GRANT;
            hmaster_q   <= DEF_IDX;
            hmastlock_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grant_idx_q <= grant_idx_d;
            ptr_q       <= ptr_d;
            hgrant_q    <= hgrant_d;
            hmaster_q   <= hmaster_d;
            hmastlock_q <= hmastlock_d;
        end
    end

    assign hgrant    = hgrant_q;
    assign hmaster   = hmaster_q;
    assign hmastlock = hmastlock_q;

endmodule
